serial_rx: RTL

UART receiver that sits directly upstream of the host-loader command FSM. It turns the asynchronous serial input pin into one byte plus a one-cycle completion or error strobe per frame. Its outputs connect straight to the loader's serial_data_in, serial_in_cplt and serial_in_error inputs. Frame format is fixed 8N1, LSB first, idle-high line.

---
 rtl/serial_pkg.sv | 19 +
 rtl/sync_ff.sv | 30 +++
 rtl/serial_rx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared serial-link definitions used by the UART receiver, the loader and the benches.
package serial_pkg;

    localparam int SERIAL_DATA_BITS = 8;
    localparam logic [7:0] SERIAL_ACK_BYTE = 8'd69;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage flip-flop synchronizer for a single asynchronous input, with a selectable reset level.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    assign sync_d[0] = d;
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_chain
        assign sync_d[gi] = sync_q[gi-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/serial_rx.sv
// 8N1 UART receiver: majority-voted mid-bit sampling, one-cycle done/framing-error strobes.
module serial_rx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_cplt,
    output logic       rx_error,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HM1  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_HP1  = CNT_W'(HALF + 1);

    logic rx_s;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    rx_state_t                       state_q, state_d;
    logic [CNT_W-1:0]                bit_cnt_q, bit_cnt_d;
    logic [2:0]                      bit_idx_q, bit_idx_d;
    logic [SERIAL_DATA_BITS-1:0]     shift_q, shift_d;
    logic [1:0]                      samp_q, samp_d;
    logic [SERIAL_DATA_BITS-1:0]     rx_data_q, rx_data_d;
    logic                            rx_cplt_q, rx_cplt_d;
    logic                            rx_error_q, rx_error_d;
    logic                            rx_busy_q, rx_busy_d;
    logic                            vote;
    logic                            sample_now;

    // The first two samples are latched; the third is the live rx_s at HALF+1.
    assign vote       = majority3(samp_q[0], samp_q[1], rx_s);
    assign sample_now = (bit_cnt_q == CNT_HP1);

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        samp_d     = samp_q;
        rx_data_d  = rx_data_q;
        rx_cplt_d  = 1'b0;
        rx_error_d = 1'b0;
        rx_busy_d  = rx_busy_q;
        bit_cnt_d  = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + 1'b1;

        if (bit_cnt_q == CNT_HM1) begin
            samp_d[0] = rx_s;
        end
        if (bit_cnt_q == CNT_HALF) begin
            samp_d[1] = rx_s;
        end

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                rx_busy_d = 1'b0;
                if (!rx_s) begin
                    state_d   = START;
                    rx_busy_d = 1'b1;
                end
            end
            START: begin
                if (sample_now) begin
                    if (!vote) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d   = IDLE;
                        rx_busy_d = 1'b0;
                    end
                end
            end
            DATA: begin
                if (sample_now) begin
                    shift_d = {vote, shift_q[SERIAL_DATA_BITS-1:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (sample_now) begin
                    if (vote) begin
                        rx_data_d = shift_q;
                        rx_cplt_d = 1'b1;
                        state_d   = IDLE;
                        rx_busy_d = 1'b0;
                    end else begin
                        rx_error_d = 1'b1;
                        state_d    = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold off until the line is released so a break is not seen as a start bit.
                if (rx_s) begin
                    state_d   = IDLE;
                    rx_busy_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                rx_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= '0;
            samp_q     <= 2'b11;
            rx_data_q  <= 8'h00;
            rx_cplt_q  <= 1'b0;
            rx_error_q <= 1'b0;
            rx_busy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            samp_q     <= samp_d;
            rx_data_q  <= rx_data_d;
            rx_cplt_q  <= rx_cplt_d;
            rx_error_q <= rx_error_d;
            rx_busy_q  <= rx_busy_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_cplt  = rx_cplt_q;
    assign rx_error = rx_error_q;
    assign rx_busy  = rx_busy_q;

endmodule
